// File: rtl/i2c_sensor_target.sv
// i2c_sensor_target: I2C target that stands in for the board's temperature/
// humidity sensor. Reads return a 16-bit measurement snapshot taken at
// address match, MSB first. Writes deliver command bytes on cmd_out/cmd_valid.
// Optional feature macro: I2C_TGT_CRC_EN adds a CRC-8 byte after the
// measurement (poly 0x31, init 0xFF). Without it, the third and later read
// bytes are 0xFF.
`timescale 1ns/1ps
module i2c_sensor_target #(
  parameter logic [6:0] ADDR = 7'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_en,
  input  logic [15:0] meas_in,
  output logic [7:0]  cmd_out,
  output logic        cmd_valid,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_RD_DATA  = 3'd4;
  localparam logic [2:0] S_RD_ACK   = 3'd5;
  localparam logic [2:0] S_IGNORE   = 3'd6;

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx;
  logic [7:0] r_snap_lo;
  logic [1:0] r_byte_cnt;
  logic       r_rw;
  logic       r_ack_ph;
  logic       r_sda_en;
  logic       r_busy;
  logic       r_cmd_valid;
  logic [7:0] r_cmd;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic [7:0] w_next_byte;

`ifdef I2C_TGT_CRC_EN
  logic [7:0] r_snap_hi;
  logic [7:0] w_crc;

  // CRC-8, poly 0x31, init 0xFF, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0] crc;
    crc = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h31;
      else                  crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

  assign w_crc = crc8({r_snap_hi, r_snap_lo});
`endif

  // Edges and bus conditions use only the synchronized, one-cycle-delayed levels.
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SCL must be high in both samples, so SDA moving together with an SCL
  // rising edge is taken as a data bit rather than START/STOP.
  assign w_start = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte  = {r_shift, r_sda_s2};

  assign sda_en    = r_sda_en;
  assign cmd_out   = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign busy      = r_busy;

  // Two-flop synchronizers plus one history stage for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // Reset to the idle-bus level so leaving reset does not look like bus activity.
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // Byte to shift out after the master ACKs the current read byte.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next_byte unassigned (no latch).
    w_next_byte = 8'hFF;
    case (r_byte_cnt)
      2'd0:    w_next_byte = r_snap_lo;
`ifdef I2C_TGT_CRC_EN
      2'd1:    w_next_byte = w_crc;
`endif
      default: w_next_byte = 8'hFF;
    endcase
  end

  // Protocol FSM: START/STOP first, then SCL-rise sampling / SCL-fall driving.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 7'd0;
      r_tx        <= 8'hFF;
      r_snap_lo   <= 8'h00;
      r_byte_cnt  <= 2'd0;
      r_rw        <= 1'b0;
      r_ack_ph    <= 1'b0;
      r_sda_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= 8'h00;
`ifdef I2C_TGT_CRC_EN
      r_snap_hi   <= 8'h00;
`endif
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_ack_ph  <= 1'b0;
        r_sda_en  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_ack_ph  <= 1'b0;
        r_sda_en  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift <= w_byte[6:0];
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= 4'd0;
              if (w_byte[7:1] == ADDR) begin
                r_busy   <= 1'b1;
                r_rw     <= w_byte[0];
                r_ack_ph <= 1'b0;
                r_state  <= S_ADDR_ACK;
                if (w_byte[0]) begin
                  // Snapshot the whole measurement now; later meas_in changes are ignored.
                  r_tx       <= meas_in[15:8];
                  r_snap_lo  <= meas_in[7:0];
                  r_byte_cnt <= 2'd0;
`ifdef I2C_TGT_CRC_EN
                  r_snap_hi  <= meas_in[15:8];
`endif
                end
              end else begin
                r_state <= S_IGNORE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          // Shared by address and write-data bytes: pull low, then release.
          S_ADDR_ACK: if (w_scl_fall) begin
            if (!r_ack_ph) begin
              r_sda_en <= 1'b1;
              r_ack_ph <= 1'b1;
            end else begin
              r_ack_ph <= 1'b0;
              if (r_rw) begin
                // The first read bit goes out on the same fall that ends the ACK.
                r_sda_en  <= ~r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b1};
                r_bit_cnt <= 4'd1;
                r_state   <= S_RD_DATA;
              end else begin
                r_sda_en  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: if (w_scl_rise) begin
            r_shift <= w_byte[6:0];
            if (r_bit_cnt == 4'd7) begin
              r_cmd       <= w_byte;
              r_cmd_valid <= 1'b1;
              r_bit_cnt   <= 4'd0;
              r_ack_ph    <= 1'b0;
              r_state     <= S_ADDR_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_RD_DATA: if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              r_sda_en  <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_RD_ACK;
            end else begin
              r_sda_en  <= ~r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b1};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_RD_ACK: if (w_scl_rise) begin
            if (!r_sda_s2) begin
              r_tx      <= w_next_byte;
              r_bit_cnt <= 4'd0;
              if (r_byte_cnt != 2'd2) r_byte_cnt <= r_byte_cnt + 2'd1;
              r_state   <= S_RD_DATA;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_sensor_target.md
# i2c_sensor_target

Synthesizable I2C target (slave) that emulates the temperature/humidity sensor on the other end of the board's I2C bus. It lets the existing I2C master and 7-segment display path be exercised in hardware-in-the-loop or simulation without the physical sensor. It answers read transactions with a 16-bit measurement snapshot, optionally followed by a CRC byte, and accepts written command bytes. It sits at the top level behind the same open-drain `ck_scl`/`ck_sda` wiring the master uses.

## Interface
- `ADDR`, 7'h40, 7-bit target address matched against the address byte.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `scl_in` in 1: raw SCL pin level (asynchronous).
- `sda_in` in 1: raw SDA pin level (asynchronous).
- `sda_en` out 1: open-drain drive. When 1, top level drives SDA low; when 0, SDA is released. This block never drives high.
- `meas_in` in 16: measurement value to report, MSB first.
- `cmd_out` out 8: last data byte written by the master.
- `cmd_valid` out 1: one-cycle pulse when `cmd_out` updates.
- `busy` out 1: high from address match until STOP, NACK, or reset.

## Operation
- **Input synchronization**
  - `scl_in` and `sda_in` each pass through a 2-flop synchronizer, then a 1-cycle history register.
  - All edge and condition detection uses the synchronized values.
- **Bus conditions**
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - START in any state, including a repeated START: go to ADDR, clear the bit counter, set `sda_en`=0.
  - STOP in any state: go to IDLE, set `sda_en`=0, `busy`=0.
- **Bit timing**
  - Sample SDA on SCL rising edges.
  - Change `sda_en` only on SCL falling edges.
- **States**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits.
    - Address match (`[7:1]==ADDR`): set `busy`=1, go to ADDR_ACK. If R/W=1, load the TX shift register with `meas_in[15:8]` and latch `meas_in[7:0]` (plus CRC) for the following bytes.
    - Mismatch: go to IGNORE. `sda_en` stays 0 until the next START/STOP.
  - ADDR_ACK: on the next SCL fall, `sda_en`=1. On the following fall, release SDA.
    - R/W=0: go to WR_DATA.
    - R/W=1: go to RD_DATA and drive the first bit on that same fall.
  - WR_DATA: shift in 8 bits.
    - On the 8th rising edge, `cmd_out`←byte and pulse `cmd_valid`.
    - ACK the byte exactly as in ADDR_ACK, then return to WR_DATA.
  - RD_DATA: on each SCL fall, `sda_en`=~bit (MSB first). After 8 bits, release SDA on the next fall and go to RD_ACK.
  - RD_ACK: sample SDA on the rising edge.
    - 0 (ACK): load the next byte, go to RD_DATA.
    - 1 (NACK): go to IGNORE, `busy`=0.
- **Byte sequence on read:** `meas[15:8]`, `meas[7:0]`, [CRC], then 0xFF (SDA released) for any further ACKed bytes.
- **Snapshot:** `meas_in` changes after address match do not affect the transaction in progress.

## Timing
- Reset values: `sda_en`=0, `cmd_out`=8'h00, `cmd_valid`=0, `busy`=0, state IDLE, counters 0.
- Reset mid-transfer releases SDA at the first clock edge with `rst`=1.
- `sda_en` changes exactly 3 `clk` cycles after an SCL pin transition (2 synchronizer stages + 1 register).
  - Requirement: SCL low time ≥ 4 cycles (40 ns), trivially met at 100 kHz.
- `cmd_valid` asserts 3 cycles after the 8th data-bit SCL rising edge at the pin.
- START and STOP take priority over bit sampling in the same cycle.
- A clock with SCL rising and SDA changing together is treated as bit sampling, not START/STOP.
- No clock stretching: SCL is never driven.

## Configuration
- `I2C_TGT_CRC_EN` defined:
  - A third read byte carries CRC-8 over the two measurement bytes.
  - Polynomial 0x31, init 0xFF, no reflection, no final XOR.
  - Computed combinationally from the snapshot at address match.
- Undefined: no CRC logic; the third and later read bytes are 0xFF.

## Test plan
- Read at 0x40 (byte 0x81), `meas_in`=16'hBEEF, master ACK, ACK, NACK + STOP → address ACKed; bytes 0xBE, 0xEF, then 0x92 with CRC_EN or 0xFF without; `busy` falls at NACK.
- Write 0x80, 0xAC, 0x33, STOP → all three bytes ACKed; `cmd_valid` pulses twice with `cmd_out` 0xAC then 0x33; final `cmd_out`=0x33.
- Address 0x71 (target 0x38) → no ACK (SDA high on the 9th clock), `sda_en` never asserted, `busy` stays 0.
- Write 0x80, 0xAC, then repeated START + 0x81 read with `meas_in`=16'h1234 → `cmd_out`=0xAC; read returns 0x12, 0x34.
- `meas_in` changes 16'h1111→16'h2222 during the first read byte → bytes returned are 0x11, 0x11.
- `rst` asserted mid-read while `sda_en`=1 → `sda_en`=0 next cycle; the next START + 0x81 is ACKed normally.
